bmp_scan_seq: RTL and testbench
===============================

BMP_SCAN_SEQ -- requirements
Module: bmp_scan_seq

Interface
REQ-001 Parameter NCOLS, default 24: number of column slices scanned.
REQ-002 Parameter NROWS, default 64: number of row slices; SHALL be even.
REQ-003 Parameter TIMEOUT, default 15: maximum cycles to wait on any ready or done input.
REQ-004 Port clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 Port rst  in  1  synchronous reset, active-high.
REQ-006 Port start  in  1  bitmap written; begin scan.
REQ-007 Port nextcol  out  1  one-cycle request for next column slice.
REQ-008 Port colready  in  1  column slice valid.
REQ-009 Port nextrowtop  out  1  one-cycle request for next top row slice.
REQ-010 Port rowtopready  in  1  top row slice valid.
REQ-011 Port nextrowbot  out  1  one-cycle request for next bottom row slice.
REQ-012 Port rowbotready  in  1  bottom row slice valid.
REQ-013 Port alu_go  out  1  one-cycle ALU start for the current slice.
REQ-014 Port alu_done  in  1  ALU result valid.
REQ-015 Port alu_match  in  1  compare hit; sampled only with alu_done.
REQ-016 Port busy  out  1  scan in progress.
REQ-017 Port done  out  1  one-cycle scan-complete pulse.
REQ-018 Port err  out  1  timeout flag; held until next accepted start or rst.
REQ-019 Port col_hits  out  $clog2(NCOLS+1)  column match count.
REQ-020 Port row_hits  out  $clog2(NROWS+1)  row match count.

Function
REQ-021 FSM states: IDLE, REQ, WAIT_RDY, GO, WAIT_ALU, FINISH; a phase register SHALL select COL, ROWT or ROWB.
REQ-022 In IDLE, start=1 SHALL clear the counters and err, set phase COL, and enter REQ next cycle; start while busy SHALL be ignored.
REQ-023 REQ SHALL pulse exactly one request output for the current phase, then go to WAIT_RDY.
REQ-024 WAIT_RDY SHALL go to GO on the matching ready; ready asserted during the REQ cycle SHALL NOT be counted.
REQ-025 GO SHALL pulse alu_go for one cycle, then go to WAIT_ALU.
REQ-026 WAIT_ALU on alu_done SHALL increment the count for the current phase if alu_match=1, then advance the item and enter REQ, or FINISH after the last item.
REQ-027 Order: NCOLS columns; then NROWS/2 pairs, each pair one ROWT item followed by one ROWB item.
REQ-028 Throughput: with ready and alu_done each returned one cycle after their pulse, each item SHALL take 4 cycles.
REQ-029 A WAIT_RDY or WAIT_ALU dwell exceeding TIMEOUT cycles SHALL set err and go to FINISH, with counts frozen.
REQ-030 FINISH SHALL pulse done for one cycle, then return to IDLE; busy SHALL be 1 in every state except IDLE.
REQ-031 Counters SHALL NOT wrap; their width covers the maximum count.

Reset
REQ-032 rst SHALL force IDLE from any state, including mid-scan, with no done pulse.
REQ-033 On rst, all outputs and counters SHALL be 0 in the following cycle.
REQ-034 rst SHALL take priority over start in the same cycle.

Configuration
REQ-035 With macro BMP_SCAN_ROWS_EN defined, the row phases SHALL run.
REQ-036 Without BMP_SCAN_ROWS_EN, the block SHALL enter FINISH after the last column; nextrowtop, nextrowbot and row_hits SHALL be tied 0.

Structure
REQ-037 Package bmp_scan_pkg SHALL hold the state and phase typedefs and the NCOLS, NROWS and TIMEOUT defaults.
REQ-038 The dwell watchdog SHALL be the sub-module bmp_scan_timeout (clear, enable, expired).

Verification
REQ-039 Macro on; start at cycle 0; responder replies 1 cycle later with alu_match always 1 -> first nextcol at cycle 1; done at cycle 353; col_hits=24; row_hits=64; err=0.
REQ-040 Macro off; same stimulus -> done at cycle 97; no row requests issued; row_hits=0.
REQ-041 Macro on; alu_match=1 on even columns and top rows only -> col_hits=12; row_hits=32.
REQ-042 Macro on; colready withheld on column 5 -> err=1 after 16 dwell cycles; done pulses; col_hits=5.
REQ-043 Macro on; rst at cycle 40 and start pulsed at cycle 41 -> no done pulse; outputs 0 at cycle 41; start ignored; fresh start later completes normally.
REQ-044 Macro on; start pulsed again mid-scan -> ignored; scan result unchanged.

Source files
------------

// File: rtl/bmp_scan_pkg.sv
// Shared types and default sizing for the bitmap scan sequencer.
package bmp_scan_pkg;

    localparam int unsigned NcolsDefault   = 24;
    localparam int unsigned NrowsDefault   = 64;
    localparam int unsigned TimeoutDefault = 15;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWaitRdy,
        StGo,
        StWaitAlu,
        StFinish
    } state_e;

    typedef enum logic [1:0] {
        PhCol,
        PhRowT,
        PhRowB
    } phase_e;

endpackage

// File: rtl/bmp_scan_timeout.sv
// Dwell watchdog: counts cycles spent waiting and flags once TIMEOUT is exceeded.
module bmp_scan_timeout
    import bmp_scan_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter holds TIMEOUT on the (TIMEOUT+1)-th waiting cycle, which is the first one over budget.
    assign expired = enable && (cnt_q == CntW'(TIMEOUT));

    // Next count: restart on clear, saturate once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bmp_scan_seq.sv
// Bitmap scan sequencer: walks column slices then top/bottom row-slice pairs through an
// external ALU, counting matches. Row phases are built only with BMP_SCAN_ROWS_EN defined.
module bmp_scan_seq
    import bmp_scan_pkg::*;
#(
    parameter int unsigned NCOLS   = NcolsDefault,
    parameter int unsigned NROWS   = NrowsDefault,
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       nextcol,
    input  logic                       colready,
    output logic                       nextrowtop,
    input  logic                       rowtopready,
    output logic                       nextrowbot,
    input  logic                       rowbotready,
    output logic                       alu_go,
    input  logic                       alu_done,
    input  logic                       alu_match,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [$clog2(NCOLS+1)-1:0] col_hits,
    output logic [$clog2(NROWS+1)-1:0] row_hits
);

    localparam int unsigned ColHitW = $clog2(NCOLS + 1);
    localparam int unsigned RowHitW = $clog2(NROWS + 1);
    localparam int unsigned ColIdxW = (NCOLS > 1) ? $clog2(NCOLS) : 1;

    state_e               state_q, state_d;
    phase_e               phase_q, phase_d;
    logic [ColIdxW-1:0]   col_idx_q, col_idx_d;
    logic [ColHitW-1:0]   col_hits_q, col_hits_d;
    logic                 err_q, err_d;
    logic                 in_wait, expired, rdy;

`ifdef BMP_SCAN_ROWS_EN
    localparam int unsigned PairIdxW = (NROWS > 2) ? $clog2(NROWS / 2) : 1;
    logic [PairIdxW-1:0]  pair_q, pair_d;
    logic [RowHitW-1:0]   row_hits_q, row_hits_d;
`else
    logic                 unused_row_rdy;
    assign unused_row_rdy = rowtopready ^ rowbotready;
`endif

    assign in_wait = (state_q == StWaitRdy) || (state_q == StWaitAlu);

    bmp_scan_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (!in_wait),
        .enable  (in_wait),
        .expired (expired)
    );

    // Select the ready input belonging to the current phase.
    always_comb begin
        rdy = colready;
`ifdef BMP_SCAN_ROWS_EN
        if (phase_q == PhRowT) begin
            rdy = rowtopready;
        end else if (phase_q == PhRowB) begin
            rdy = rowbotready;
        end
`endif
    end

    // Next-state, item advance and match counting.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        col_idx_d  = col_idx_q;
        col_hits_d = col_hits_q;
        err_d      = err_q;
`ifdef BMP_SCAN_ROWS_EN
        pair_d     = pair_q;
        row_hits_d = row_hits_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StReq;
                    phase_d    = PhCol;
                    col_idx_d  = '0;
                    col_hits_d = '0;
                    err_d      = 1'b0;
`ifdef BMP_SCAN_ROWS_EN
                    pair_d     = '0;
                    row_hits_d = '0;
`endif
                end
            end
            StReq: state_d = StWaitRdy;
            StWaitRdy: begin
                // A ready arriving on the last allowed cycle still wins over the watchdog.
                if (rdy) begin
                    state_d = StGo;
                end else if (expired) begin
                    state_d = StFinish;
                    err_d   = 1'b1;
                end
            end
            StGo: state_d = StWaitAlu;
            StWaitAlu: begin
                if (alu_done) begin
                    state_d = StReq;
                    case (phase_q)
                        PhCol: begin
                            if (alu_match && (col_hits_q != ColHitW'(NCOLS))) begin
                                col_hits_d = col_hits_q + ColHitW'(1);
                            end
                            if (col_idx_q == ColIdxW'(NCOLS - 1)) begin
`ifdef BMP_SCAN_ROWS_EN
                                phase_d = PhRowT;
`else
                                state_d = StFinish;
`endif
                            end else begin
                                col_idx_d = col_idx_q + ColIdxW'(1);
                            end
                        end
`ifdef BMP_SCAN_ROWS_EN
                        PhRowT: begin
                            if (alu_match && (row_hits_q != RowHitW'(NROWS))) begin
                                row_hits_d = row_hits_q + RowHitW'(1);
                            end
                            phase_d = PhRowB;
                        end
                        PhRowB: begin
                            if (alu_match && (row_hits_q != RowHitW'(NROWS))) begin
                                row_hits_d = row_hits_q + RowHitW'(1);
                            end
                            if (pair_q == PairIdxW'(NROWS / 2 - 1)) begin
                                state_d = StFinish;
                            end else begin
                                pair_d  = pair_q + PairIdxW'(1);
                                phase_d = PhRowT;
                            end
                        end
`endif
                        default: state_d = StFinish;
                    endcase
                end else if (expired) begin
                    state_d = StFinish;
                    err_d   = 1'b1;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset wins over everything, start included.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            phase_q    <= PhCol;
            col_idx_q  <= '0;
            col_hits_q <= '0;
            err_q      <= 1'b0;
`ifdef BMP_SCAN_ROWS_EN
            pair_q     <= '0;
            row_hits_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            col_idx_q  <= col_idx_d;
            col_hits_q <= col_hits_d;
            err_q      <= err_d;
`ifdef BMP_SCAN_ROWS_EN
            pair_q     <= pair_d;
            row_hits_q <= row_hits_d;
`endif
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFinish);
    assign alu_go   = (state_q == StGo);
    assign nextcol  = (state_q == StReq) && (phase_q == PhCol);
    assign err      = err_q;
    assign col_hits = col_hits_q;
`ifdef BMP_SCAN_ROWS_EN
    assign nextrowtop = (state_q == StReq) && (phase_q == PhRowT);
    assign nextrowbot = (state_q == StReq) && (phase_q == PhRowB);
    assign row_hits   = row_hits_q;
`else
    assign nextrowtop = 1'b0;
    assign nextrowbot = 1'b0;
    assign row_hits   = '0;
`endif

endmodule

// File: tb/tb_bmp_scan_seq.sv
// Self-checking bench for bmp_scan_seq; expectations follow BMP_SCAN_ROWS_EN if defined.
module tb_bmp_scan_seq;

    localparam int unsigned NC = 24;
    localparam int unsigned NR = 64;
    localparam int unsigned TO = 15;
`ifdef BMP_SCAN_ROWS_EN
    localparam int unsigned RowsEn = 1;
`else
    localparam int unsigned RowsEn = 0;
`endif

    typedef struct {
        int unsigned lat;
        int unsigned col;
        int unsigned row;
        int unsigned err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic colready = 1'b0, rowtopready = 1'b0, rowbotready = 1'b0;
    logic alu_done = 1'b0, alu_match = 1'b0;
    logic nextcol, nextrowtop, nextrowbot, alu_go, busy, done, err;
    logic [$clog2(NC+1)-1:0] col_hits;
    logic [$clog2(NR+1)-1:0] row_hits;

    bmp_scan_seq #(
        .NCOLS   (NC),
        .NROWS   (NR),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .nextcol     (nextcol),
        .colready    (colready),
        .nextrowtop  (nextrowtop),
        .rowtopready (rowtopready),
        .nextrowbot  (nextrowbot),
        .rowbotready (rowbotready),
        .alu_go      (alu_go),
        .alu_done    (alu_done),
        .alu_match   (alu_match),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .col_hits    (col_hits),
        .row_hits    (row_hits)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned checks = 0;
    int unsigned passes = 0;
    exp_t sb[$];

    // Responder state
    int match_mode = 0;
    int withhold_col = -1;
    int n_col_req = 0, n_rt_req = 0, n_rb_req = 0;
    int order_err = 0;
    int last_kind = 0;
    int cur_kind = 0, cur_idx = 0;
    int done_cnt = 0;
    bit pend_col = 0, pend_rt = 0, pend_rb = 0, pend_go = 0, pend_match = 0;

    function automatic bit match_fn(input int kind, input int idx);
        if (match_mode == 0) return 1'b1;
        if (kind == 1) return (idx % 2) == 0;
        if (kind == 2) return 1'b1;
        return 1'b0;
    endfunction

    // Responder: answers each request or alu_go one cycle later and tracks request order.
    always @(negedge clk) begin
        colready    = pend_col;
        rowtopready = pend_rt;
        rowbotready = pend_rb;
        alu_done    = pend_go;
        alu_match   = pend_go & pend_match;
        pend_col = 0; pend_rt = 0; pend_rb = 0; pend_go = 0;
        if (done) done_cnt++;
        if (int'(nextcol) + int'(nextrowtop) + int'(nextrowbot) > 1) order_err++;
        if (nextcol) begin
            if (last_kind > 1) order_err++;
            if (n_col_req != withhold_col) pend_col = 1;
            cur_kind = 1; cur_idx = n_col_req; n_col_req++; last_kind = 1;
        end
        if (nextrowtop) begin
            if (!((last_kind == 1 && n_col_req == NC) || last_kind == 3)) order_err++;
            pend_rt = 1;
            cur_kind = 2; cur_idx = n_rt_req; n_rt_req++; last_kind = 2;
        end
        if (nextrowbot) begin
            if (last_kind != 2) order_err++;
            pend_rb = 1;
            cur_kind = 3; cur_idx = n_rb_req; n_rb_req++; last_kind = 3;
        end
        if (alu_go) begin
            pend_go = 1;
            pend_match = match_fn(cur_kind, cur_idx);
        end
    end

    task automatic do_start(output int unsigned s);
        @(negedge clk);
        n_col_req = 0; n_rt_req = 0; n_rb_req = 0; order_err = 0; last_kind = 0;
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget, output bit seen, output int unsigned at,
                             output int unsigned ch, output int unsigned rh,
                             output int unsigned e);
        seen = 0; at = 0; ch = 0; rh = 0; e = 0;
        for (int i = 0; i < int'(budget); i++) begin
            if (done) begin
                seen = 1; at = cyc; ch = col_hits; rh = row_hits; e = err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, nextcol, nextrowtop, nextrowbot, alu_go} !== 7'b0) begin
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {busy, done, err, nextcol, nextrowtop, nextrowbot, alu_go});
        end else passes++;
        checks++;
        if (col_hits !== '0 || row_hits !== '0) begin
            $display("FAIL reset_hits: got col=%0d row=%0d required 0/0", col_hits, row_hits);
        end else passes++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end else passes++;
    endtask

    task automatic run_and_check(input string name, input int unsigned budget);
        int unsigned s, at, ch, rh, e;
        bit seen;
        exp_t x;
        do_start(s);
        wait_done(budget, seen, at, ch, rh, e);
        x = sb.pop_front();
        checks++;
        if (!seen) $display("FAIL %s_done_seen: got no done within %0d cycles, required one", name, budget);
        else passes++;
        checks++;
        if (at - s !== x.lat) $display("FAIL %s_latency: got %0d required %0d", name, at - s, x.lat);
        else passes++;
        checks++;
        if (ch !== x.col) $display("FAIL %s_col_hits: got %0d required %0d", name, ch, x.col);
        else passes++;
        checks++;
        if (rh !== x.row) $display("FAIL %s_row_hits: got %0d required %0d", name, rh, x.row);
        else passes++;
        checks++;
        if (e !== x.err) $display("FAIL %s_err: got %0d required %0d", name, e, x.err);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL %s_after_done: got done=%b busy=%b required 0/0", name, done, busy);
        end else passes++;
    endtask

    task automatic test_full_scan();
        match_mode = 0; withhold_col = -1;
        sb.push_back('{lat: 4 * (NC + RowsEn * NR) + 1, col: NC, row: RowsEn * NR, err: 0});
        run_and_check("full", 600);
        checks++;
        if (n_col_req != NC) $display("FAIL full_col_reqs: got %0d required %0d", n_col_req, NC);
        else passes++;
        checks++;
        if (n_rt_req != int'(RowsEn * NR / 2) || n_rb_req != int'(RowsEn * NR / 2)) begin
            $display("FAIL full_row_reqs: got top=%0d bot=%0d required %0d each",
                     n_rt_req, n_rb_req, RowsEn * NR / 2);
        end else passes++;
        checks++;
        if (order_err != 0) $display("FAIL full_order: got %0d violations required 0", order_err);
        else passes++;
    endtask

    task automatic test_match_pattern();
        match_mode = 1; withhold_col = -1;
        sb.push_back('{lat: 4 * (NC + RowsEn * NR) + 1, col: NC / 2, row: RowsEn * NR / 2, err: 0});
        run_and_check("pattern", 600);
        match_mode = 0;
    endtask

    task automatic test_timeout();
        int unsigned s;
        match_mode = 0; withhold_col = 5;
        sb.push_back('{lat: 4 * 5 + 3 + TO, col: 5, row: 0, err: 1});
        run_and_check("timeout", 200);
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1 || col_hits !== 5) begin
            $display("FAIL timeout_held: got err=%b col=%0d required 1/5", err, col_hits);
        end else passes++;
        withhold_col = -1;
        sb.push_back('{lat: 4 * (NC + RowsEn * NR) + 1, col: NC, row: RowsEn * NR, err: 0});
        do_start(s);
        checks++;
        if (err !== 1'b0 || col_hits !== '0) begin
            $display("FAIL timeout_clear_on_start: got err=%b col=%0d required 0/0", err, col_hits);
        end else passes++;
        // let this scan finish and drop its entry; it is re-checked elsewhere
        for (int i = 0; i < 600 && busy; i++) @(negedge clk);
        void'(sb.pop_back());
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int unsigned s, d0;
        match_mode = 0; withhold_col = -1;
        do_start(s);
        while (cyc < s + 40) @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, nextcol, nextrowtop, nextrowbot, alu_go} !== 7'b0 ||
            col_hits !== '0 || row_hits !== '0) begin
            $display("FAIL rst_mid_outputs: got ctrl=%b col=%0d row=%0d required all 0",
                     {busy, done, err, nextcol, nextrowtop, nextrowbot, alu_go}, col_hits, row_hits);
        end else passes++;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL rst_over_start: got busy=%b required 0", busy);
        else passes++;
        repeat (400) @(negedge clk);
        checks++;
        if (done_cnt != int'(d0) || busy !== 1'b0) begin
            $display("FAIL rst_no_done: got %0d done pulses busy=%b required 0/0",
                     done_cnt - int'(d0), busy);
        end else passes++;
        sb.push_back('{lat: 4 * (NC + RowsEn * NR) + 1, col: NC, row: RowsEn * NR, err: 0});
        run_and_check("after_rst", 600);
    endtask

    task automatic test_back_to_back_start();
        int unsigned s, at, ch, rh, e, d0;
        bit seen;
        exp_t x;
        match_mode = 1; withhold_col = -1;
        sb.push_back('{lat: 4 * (NC + RowsEn * NR) + 1, col: NC / 2, row: RowsEn * NR / 2, err: 0});
        do_start(s);
        d0 = done_cnt;
        while (cyc < s + 50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(600, seen, at, ch, rh, e);
        x = sb.pop_front();
        checks++;
        if (!seen || at - s !== x.lat) begin
            $display("FAIL busy_start_latency: got seen=%0d lat=%0d required 1/%0d", seen, at - s, x.lat);
        end else passes++;
        checks++;
        if (ch !== x.col || rh !== x.row || e !== x.err) begin
            $display("FAIL busy_start_result: got col=%0d row=%0d err=%0d required %0d/%0d/%0d",
                     ch, rh, e, x.col, x.row, x.err);
        end else passes++;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt != int'(d0) + 1) begin
            $display("FAIL busy_start_single: got busy=%b pulses=%0d required 0/1",
                     busy, done_cnt - int'(d0));
        end else passes++;
        match_mode = 0;
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_match_pattern();
        test_timeout();
        test_reset_mid_scan();
        test_back_to_back_start();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
